// File: rtl/ddr3_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_rd_pkg
// Description : Shared constants, FSM state encoding and the CAS-latency
//               clamp helper for the DDR3 read capture control stage.
// Contents    : DW     - ring buffer beat width
//               BURST  - beats per burst
//               PTR_W  - ring buffer read pointer width
//               rd_state_e - read FSM states
//               clamp_cl() - limits cl to the legal range [2, max_cl]
// Revision    : 1.0 - initial release
// ============================================================================
package ddr3_rd_pkg;

    localparam int DW    = 16;
    localparam int BURST = 8;
    localparam int PTR_W = 3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_LAT = 3'd1,
        S_LISTEN   = 3'd2,
        S_SETTLE   = 3'd3,
        S_DRAIN    = 3'd4
    } rd_state_e;

    // Latencies below 2 cannot be honoured because the state machine needs
    // one cycle in WAIT_LAT plus one in LISTEN.
    function automatic int clamp_cl(input int cl, input int max_cl);
        if (cl < 2) begin
            return 2;
        end
        if (cl > max_cl) begin
            return max_cl;
        end
        return cl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr3_rd_assembler.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_rd_assembler
// Description : Captures the eight ring-buffer beats of a burst into lanes,
//               packs them into one word and holds it in a valid/ready
//               output register. A completed word arriving while the output
//               register is full and not being drained is dropped and
//               flagged in the sticky err_ovf.
// Option      : DDR3_RD_TAG_EN - carries a read tag alongside the word.
// Ports       : clk, reset     - clock, synchronous active-high reset
//               i_cap_en       - capture i_beat into lane i_cap_idx
//               i_cap_idx      - lane index for this beat
//               i_cap_last     - final beat; word offered on this edge
//               i_beat         - beat data from the ring buffer
//               i_rd_ready     - consumer ready
//               o_rd_valid     - output word valid
//               o_rd_data      - packed word, beat k at [DW*k +: DW]
//               o_err_ovf      - sticky overflow flag
//               i_tag/o_rd_tag - read tag (DDR3_RD_TAG_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_rd_assembler
    import ddr3_rd_pkg::*;
#(
`ifdef DDR3_RD_TAG_EN
    parameter int TAG_W = 4
`endif
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_cap_en,
    input  logic [PTR_W-1:0]      i_cap_idx,
    input  logic                  i_cap_last,
    input  logic [DW-1:0]         i_beat,
    input  logic                  i_rd_ready,
    output logic                  o_rd_valid,
    output logic [DW*BURST-1:0]   o_rd_data,
    output logic                  o_err_ovf
`ifdef DDR3_RD_TAG_EN
    ,
    input  logic [TAG_W-1:0]      i_tag,
    output logic [TAG_W-1:0]      o_rd_tag
`endif
);

    logic [DW-1:0]       r_lane [BURST];
    logic [DW*BURST-1:0] w_word;
    logic [DW*BURST-1:0] r_rd_data;
    logic                r_rd_valid;
    logic                r_err_ovf;
`ifdef DDR3_RD_TAG_EN
    logic [TAG_W-1:0]    r_rd_tag;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < BURST; k++) begin
                r_lane[k] <= '0;
            end
        end else if (i_cap_en) begin
            r_lane[i_cap_idx] <= i_beat;
        end
    end

    // The last beat bypasses its lane register so the full word can be
    // offered on the same edge that ends the drain.
    for (genvar k = 0; k < BURST; k++) begin : g_lane
        assign w_word[k*DW +: DW] = (i_cap_idx == PTR_W'(k)) ? i_beat : r_lane[k];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_err_ovf  <= 1'b0;
`ifdef DDR3_RD_TAG_EN
            r_rd_tag   <= '0;
`endif
        end else if (i_cap_last) begin
            if (!r_rd_valid || i_rd_ready) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= w_word;
`ifdef DDR3_RD_TAG_EN
                r_rd_tag   <= i_tag;
`endif
            end else begin
                // Output still owned by the consumer: keep it, lose the new word.
                r_err_ovf <= 1'b1;
            end
        end else if (i_rd_ready) begin
            r_rd_valid <= 1'b0;
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_err_ovf  = r_err_ovf;
`ifdef DDR3_RD_TAG_EN
    assign o_rd_tag   = r_rd_tag;
`endif

endmodule
`default_nettype wire

// File: rtl/ddr3_read_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_read_capture_ctrl
// Description : Read-side control downstream of the DDR3 8-deep input ring
//               buffer. Times each accepted read through CAS latency, pulses
//               listen to arm the buffer, waits for the burst to settle,
//               steps readPtr 0..7 and hands the beats to the assembler,
//               which packs them into a 128-bit valid/ready word.
// Option      : DDR3_RD_TAG_EN - adds rd_tag_in/rd_tag carried per burst.
// Ports       : clk, reset  - clock, synchronous active-high reset
//               rd_issue    - READ command issued this cycle
//               cl          - CAS latency, sampled on accepted rd_issue
//               rb_dout     - ring buffer data at readPtr
//               listen      - one-cycle arm pulse to the ring buffer
//               readPtr     - ring buffer read pointer
//               rd_valid / rd_ready / rd_data - output word handshake
//               busy        - FSM not idle
//               err_busy    - pulse: rd_issue dropped while busy
//               err_ovf     - sticky: completed word dropped
//               rd_tag_in / rd_tag - read tag (DDR3_RD_TAG_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_read_capture_ctrl
    import ddr3_rd_pkg::*;
#(
    parameter int CL_W       = 4,
    parameter int MAX_CL     = 11,
    parameter int SETTLE_CYC = 3
`ifdef DDR3_RD_TAG_EN
    ,
    parameter int TAG_W      = 4
`endif
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_issue,
    input  logic [CL_W-1:0]       cl,
    input  logic [DW-1:0]         rb_dout,
    output logic                  listen,
    output logic [PTR_W-1:0]      readPtr,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DW*BURST-1:0]   rd_data,
    output logic                  busy,
    output logic                  err_busy,
    output logic                  err_ovf
`ifdef DDR3_RD_TAG_EN
    ,
    input  logic [TAG_W-1:0]      rd_tag_in,
    output logic [TAG_W-1:0]      rd_tag
`endif
);

    localparam int c_LAT_W = $clog2(MAX_CL + 1);
    localparam int c_SET_W = $clog2(SETTLE_CYC + 1);

    rd_state_e           r_state;
    logic [c_LAT_W-1:0]  r_lat_cnt;
    logic [c_SET_W-1:0]  r_settle_cnt;
    logic                r_listen;
    logic                r_busy;
    logic                r_err_busy;
    logic [PTR_W-1:0]    r_read_ptr;
`ifdef DDR3_RD_TAG_EN
    logic [TAG_W-1:0]    r_tag;
`endif

    logic [c_LAT_W-1:0]  w_lat_load;
    logic                w_cap_en;
    logic                w_cap_last;

    // WAIT_LAT spends lat_cnt+1 cycles and LISTEN follows, so loading
    // cl_eff-2 puts the listen pulse exactly cl_eff cycles after rd_issue.
    assign w_lat_load = c_LAT_W'(clamp_cl(int'(cl), MAX_CL) - 2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_lat_cnt    <= '0;
            r_settle_cnt <= '0;
            r_listen     <= 1'b0;
            r_busy       <= 1'b0;
            r_err_busy   <= 1'b0;
            r_read_ptr   <= '0;
        end else begin
            r_listen   <= 1'b0;
            r_err_busy <= rd_issue && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (rd_issue) begin
                        r_lat_cnt <= w_lat_load;
                        r_busy    <= 1'b1;
                        r_state   <= S_WAIT_LAT;
                    end
                end
                S_WAIT_LAT: begin
                    if (r_lat_cnt == '0) begin
                        r_listen <= 1'b1;
                        r_state  <= S_LISTEN;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - c_LAT_W'(1);
                    end
                end
                S_LISTEN: begin
                    r_settle_cnt <= c_SET_W'(SETTLE_CYC - 1);
                    r_state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_read_ptr <= '0;
                        r_state    <= S_DRAIN;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - c_SET_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_read_ptr == PTR_W'(BURST - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_read_ptr <= r_read_ptr + PTR_W'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DDR3_RD_TAG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag <= '0;
        end else if (rd_issue && (r_state == S_IDLE)) begin
            r_tag <= rd_tag_in;
        end
    end
`endif

    assign w_cap_en   = (r_state == S_DRAIN);
    assign w_cap_last = w_cap_en && (r_read_ptr == PTR_W'(BURST - 1));

    ddr3_rd_assembler
`ifdef DDR3_RD_TAG_EN
        #(.TAG_W(TAG_W))
`endif
    u_assembler (
        .clk        (clk),
        .reset      (reset),
        .i_cap_en   (w_cap_en),
        .i_cap_idx  (r_read_ptr),
        .i_cap_last (w_cap_last),
        .i_beat     (rb_dout),
        .i_rd_ready (rd_ready),
        .o_rd_valid (rd_valid),
        .o_rd_data  (rd_data),
        .o_err_ovf  (err_ovf)
`ifdef DDR3_RD_TAG_EN
        ,
        .i_tag      (r_tag),
        .o_rd_tag   (rd_tag)
`endif
    );

    assign listen   = r_listen;
    assign readPtr  = r_read_ptr;
    assign busy     = r_busy;
    assign err_busy = r_err_busy;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_read_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr3_read_capture_ctrl
// Description : Self-checking bench for ddr3_read_capture_ctrl. Stimulus
//               pushes the expected word of each burst into a queue; a
//               monitor pops and compares on every rd_valid & rd_ready.
//               The ring buffer model returns base ^ readPtr.
// Option      : DDR3_RD_TAG_EN - also checks rd_tag per word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_read_capture_ctrl;

    logic          clk = 1'b0;
    logic          reset;
    logic          rd_issue;
    logic [3:0]    cl;
    logic [15:0]   rb_dout;
    logic          listen;
    logic [2:0]    readPtr;
    logic          rd_valid;
    logic          rd_ready;
    logic [127:0]  rd_data;
    logic          busy;
    logic          err_busy;
    logic          err_ovf;
    logic [3:0]    rd_tag_in;
`ifdef DDR3_RD_TAG_EN
    logic [3:0]    rd_tag;
`endif

    logic [15:0]   rb_base;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   tag;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errs   = 0;

    always #5 clk = ~clk;

    assign rb_dout = rb_base ^ {13'd0, readPtr};

    ddr3_read_capture_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .rd_issue  (rd_issue),
        .cl        (cl),
        .rb_dout   (rb_dout),
        .listen    (listen),
        .readPtr   (readPtr),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .busy      (busy),
        .err_busy  (err_busy),
        .err_ovf   (err_ovf)
`ifdef DDR3_RD_TAG_EN
        ,
        .rd_tag_in (rd_tag_in),
        .rd_tag    (rd_tag)
`endif
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every completed handshake must match the queue head.
    always @(negedge clk) begin
        if (!reset && rd_valid && rd_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL sb_unexpected: got %0h expected no word", rd_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_data", rd_data, e.data);
`ifdef DDR3_RD_TAG_EN
                chk("sb_tag", {124'd0, rd_tag}, {124'd0, e.tag});
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    // One read: issue at T0, then observe T0..T(cl_eff+13).
    // ready_cyc: cycle in which rd_ready is raised (-1 = untouched).
    // extra_t:   cycle in which a second rd_issue is driven (-1 = none).
    task automatic run_read(input logic [3:0] c, input int cl_eff, input logic [15:0] base,
                            input logic [127:0] exp_word, input logic [3:0] tag,
                            input bit push, input bit chk_valid, input int ready_cyc,
                            input int extra_t, output logic valid_at_load,
                            output int eb_first, output int eb_cnt);
        int lis_first = -1;
        int lis_cnt   = 0;
        int ptr_bad   = 0;
        int v_first   = -1;
        exp_t e;
        eb_first = -1;
        eb_cnt   = 0;
        valid_at_load = 1'b0;
        @(posedge clk); #1;
        rd_issue = 1'b1; cl = c; rb_base = base; rd_tag_in = tag;
        if (push) begin
            e.data = exp_word;
            e.tag  = tag;
            q.push_back(e);
        end
        for (int t = 0; t < cl_eff + 14; t++) begin
            @(negedge clk);
            if (listen) begin
                if (lis_first < 0) lis_first = t;
                lis_cnt++;
            end
            if (err_busy) begin
                if (eb_first < 0) eb_first = t;
                eb_cnt++;
            end
            if (t >= cl_eff + 4 && t < cl_eff + 12 && int'(readPtr) != t - (cl_eff + 4))
                ptr_bad++;
            if (rd_valid && v_first < 0) v_first = t;
            if (t == cl_eff + 12) valid_at_load = rd_valid;
            if (t == 1) chk("busy_t1", {127'd0, busy}, 128'd1);
            @(posedge clk); #1;
            if (t == 0) rd_issue = 1'b0;
            if (t + 1 == ready_cyc) rd_ready = 1'b1;
            if (t + 1 == extra_t) begin rd_issue = 1'b1; cl = 4'd2; end
            if (t == extra_t) rd_issue = 1'b0;
        end
        chk("listen_cycle", 128'(lis_first), 128'(cl_eff));
        chk("listen_count", 128'(lis_cnt), 128'd1);
        chk("readptr_seq", 128'(ptr_bad), 128'd0);
        if (chk_valid) chk("valid_cycle", 128'(v_first), 128'(cl_eff + 12));
    endtask

    initial begin
        logic va;
        int   ebf, ebc, ptr_bad;
        reset = 1'b1; rd_issue = 1'b0; cl = 4'd0; rd_ready = 1'b1;
        rb_base = 16'h0000; rd_tag_in = 4'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_listen",   {127'd0, listen},   128'd0);
        chk("rst_readptr",  {125'd0, readPtr},  128'd0);
        chk("rst_valid",    {127'd0, rd_valid}, 128'd0);
        chk("rst_data",     rd_data,            128'd0);
        chk("rst_busy",     {127'd0, busy},     128'd0);
        chk("rst_err_busy", {127'd0, err_busy}, 128'd0);
        chk("rst_err_ovf",  {127'd0, err_ovf},  128'd0);

        // Basic read, cl=5.
        run_read(4'd5, 5, 16'h0000, 128'h0007_0006_0005_0004_0003_0002_0001_0000,
                 4'h1, 1'b1, 1'b1, -1, -1, va, ebf, ebc);
        // Clamping low and high.
        run_read(4'd0, 2, 16'hA5A0, 128'hA5A7_A5A6_A5A5_A5A4_A5A3_A5A2_A5A1_A5A0,
                 4'h2, 1'b1, 1'b1, -1, -1, va, ebf, ebc);
        run_read(4'd15, 11, 16'h1230, 128'h1237_1236_1235_1234_1233_1232_1231_1230,
                 4'h3, 1'b1, 1'b1, -1, -1, va, ebf, ebc);

        // Overflow: consumer stalled across two bursts.
        rd_ready = 1'b0;
        run_read(4'd5, 5, 16'h3C00, 128'h3C07_3C06_3C05_3C04_3C03_3C02_3C01_3C00,
                 4'h4, 1'b1, 1'b1, -1, -1, va, ebf, ebc);
        run_read(4'd5, 5, 16'hBEE0, 128'd0, 4'h5, 1'b0, 1'b0, -1, -1, va, ebf, ebc);
        chk("ovf_hold_data", rd_data, 128'h3C07_3C06_3C05_3C04_3C03_3C02_3C01_3C00);
        chk("ovf_hold_valid", {127'd0, rd_valid}, 128'd1);
        chk("ovf_flag", {127'd0, err_ovf}, 128'd1);
        @(posedge clk); #1 rd_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("ovf_sticky", {127'd0, err_ovf}, 128'd1);
        chk("ovf_drained", {127'd0, rd_valid}, 128'd0);

        // Back-to-back load: ready rises on the cycle the second word lands.
        pulse_reset();
        rd_ready = 1'b0;
        run_read(4'd5, 5, 16'h5550, 128'h5557_5556_5555_5554_5553_5552_5551_5550,
                 4'h6, 1'b1, 1'b1, -1, -1, va, ebf, ebc);
        run_read(4'd6, 6, 16'h6660, 128'h6667_6666_6665_6664_6663_6662_6661_6660,
                 4'h7, 1'b1, 1'b0, 17, -1, va, ebf, ebc);
        chk("b2b_valid_kept", {127'd0, va}, 128'd1);
        chk("b2b_no_ovf", {127'd0, err_ovf}, 128'd0);

        // Drop rule: second rd_issue during SETTLE (T7).
        run_read(4'd5, 5, 16'h9990, 128'h9997_9996_9995_9994_9993_9992_9991_9990,
                 4'h8, 1'b1, 1'b1, -1, 7, va, ebf, ebc);
        chk("errbusy_cycle", 128'(ebf), 128'd8);
        chk("errbusy_count", 128'(ebc), 128'd1);

        // Reset in DRAIN cycle 3 with a held word in the output register.
        rd_ready = 1'b0;
        run_read(4'd5, 5, 16'h7770, 128'd0, 4'h9, 1'b0, 1'b1, -1, -1, va, ebf, ebc);
        chk("pre_rst_valid", {127'd0, rd_valid}, 128'd1);
        @(posedge clk); #1 rd_issue = 1'b1; cl = 4'd5; rb_base = 16'h4440;
        @(posedge clk); #1 rd_issue = 1'b0;
        repeat (11) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("drain3_ptr", {125'd0, readPtr}, 128'd3);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy",  {127'd0, busy},     128'd0);
        chk("mid_rst_valid", {127'd0, rd_valid}, 128'd0);
        ptr_bad = 0;
        for (int t = 0; t < 10; t++) begin
            if (readPtr != 3'd0 || listen || busy) ptr_bad++;
            @(negedge clk);
        end
        chk("mid_rst_quiet", 128'(ptr_bad), 128'd0);
        rd_ready = 1'b1;
        run_read(4'd7, 7, 16'hC0D0, 128'hC0D7_C0D6_C0D5_C0D4_C0D3_C0D2_C0D1_C0D0,
                 4'hB, 1'b1, 1'b1, -1, -1, va, ebf, ebc);

`ifdef DDR3_RD_TAG_EN
        run_read(4'd5, 5, 16'hE0E0, 128'hE0E7_E0E6_E0E5_E0E4_E0E3_E0E2_E0E1_E0E0,
                 4'hA, 1'b1, 1'b1, -1, -1, va, ebf, ebc);
        run_read(4'd4, 4, 16'hF0F0, 128'hF0F7_F0F6_F0F5_F0F4_F0F3_F0F2_F0F1_F0F0,
                 4'h5, 1'b1, 1'b1, -1, -1, va, ebf, ebc);
`endif

        repeat (5) @(negedge clk);
        chk("sb_empty", 128'(q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire
